// File: rtl/switch_control.sv
// rtl/switch_control.sv - round-robin header arbitration, XY routing and output allocation for one router
module switch_control #(
  parameter int NPORT   = 5,
  parameter int ADDR_W  = 8,
  parameter int LOCAL_X = 1,
  parameter int LOCAL_Y = 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NPORT-1:0]                   i_h,
  input  logic [NPORT*ADDR_W-1:0]            i_header_addr,
  input  logic [NPORT-1:0]                   i_release,
  output logic [NPORT-1:0]                   o_ack_h,
  output logic [NPORT-1:0]                   o_out_busy,
  output logic [NPORT*$clog2(NPORT)-1:0]     o_mux_out,
  output logic [$clog2(NPORT)-1:0]           o_selected_in
);

  localparam int SEL_W  = $clog2(NPORT);
  localparam int HALF_W = ADDR_W / 2;

  localparam logic [SEL_W-1:0] P_EAST  = SEL_W'(0);
  localparam logic [SEL_W-1:0] P_WEST  = SEL_W'(1);
  localparam logic [SEL_W-1:0] P_NORTH = SEL_W'(2);
  localparam logic [SEL_W-1:0] P_SOUTH = SEL_W'(3);
  localparam logic [SEL_W-1:0] P_LOCAL = SEL_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   dst;

  logic               arb_found;
  logic [SEL_W-1:0]   arb_idx;
  logic [ADDR_W-1:0]  route_addr;
  logic [HALF_W-1:0]  route_tx;
  logic [HALF_W-1:0]  route_ty;
  logic [SEL_W-1:0]   route_dst;

  assign o_selected_in = sel;

  // Rotated fixed-priority search: lowest requester above ptr wins, else lowest requester overall.
  always_comb begin
    arb_found = |i_h;
    arb_idx   = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (i_h[i]) arb_idx = SEL_W'(i);
    end
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (i_h[i] && (i > int'(ptr))) arb_idx = SEL_W'(i);
    end
  end

  // XY routing of the selected input's header: resolve X first, then Y, then deliver locally.
  always_comb begin
    route_addr = i_header_addr[int'(sel)*ADDR_W +: ADDR_W];
    route_tx   = route_addr[ADDR_W-1 -: HALF_W];
    route_ty   = route_addr[HALF_W-1:0];
    if (route_tx > HALF_W'(LOCAL_X))      route_dst = P_EAST;
    else if (route_tx < HALF_W'(LOCAL_X)) route_dst = P_WEST;
    else if (route_ty > HALF_W'(LOCAL_Y)) route_dst = P_NORTH;
    else if (route_ty < HALF_W'(LOCAL_Y)) route_dst = P_SOUTH;
    else                                  route_dst = P_LOCAL;
  end

  // Arbitration FSM plus output allocation; releases apply every cycle and a same-edge grant overrides them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= SEL_W'(NPORT - 1);
      sel        <= '0;
      dst        <= '0;
      o_ack_h    <= '0;
      o_out_busy <= '0;
      o_mux_out  <= '0;
    end else begin
      o_ack_h    <= '0;
      o_out_busy <= o_out_busy & ~i_release;
      case (state)
        S_IDLE: begin
          if (|i_h) state <= S_ARB;
        end
        S_ARB: begin
          if (arb_found) begin
            sel   <= arb_idx;
            ptr   <= arb_idx;
            state <= S_ROUTE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ROUTE: begin
          if (!i_h[sel]) begin
            state <= S_IDLE;
          end else if (!o_out_busy[route_dst]) begin
            dst   <= route_dst;
            state <= S_GRANT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GRANT: begin
          o_ack_h[sel]                          <= 1'b1;
          o_out_busy[dst]                       <= 1'b1;
          o_mux_out[int'(dst)*SEL_W +: SEL_W]   <= sel;
          state                                 <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// tb/tb_switch_control.sv - scoreboard bench for switch_control
module tb_switch_control;

  localparam int NPORT  = 5;
  localparam int ADDR_W = 8;
  localparam int SEL_W  = 3;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic [NPORT-1:0]          i_h = '0;
  logic [NPORT*ADDR_W-1:0]   i_header_addr = '0;
  logic [NPORT-1:0]          i_release = '0;
  logic [NPORT-1:0]          o_ack_h;
  logic [NPORT-1:0]          o_out_busy;
  logic [NPORT*SEL_W-1:0]    o_mux_out;
  logic [SEL_W-1:0]          o_selected_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sb[$];
  int ack_log[$];
  int mon_e, mon_p, mon_d;

  logic [7:0] xy_addr [5] = '{8'h01, 8'h12, 8'h10, 8'h11, 8'h31};
  int         xy_dst  [5] = '{1, 2, 3, 4, 0};
  logic [7:0] rr_addr [5] = '{8'h21, 8'h01, 8'h12, 8'h10, 8'h11};

  switch_control dut (
    .clock         (clock),
    .reset         (reset),
    .i_h           (i_h),
    .i_header_addr (i_header_addr),
    .i_release     (i_release),
    .o_ack_h       (o_ack_h),
    .o_out_busy    (o_out_busy),
    .o_mux_out     (o_mux_out),
    .o_selected_in (o_selected_in)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Grant monitor: pop the expected grant, compare, then the requester drops its header request.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && (o_ack_h != '0)) begin
        ack_log.push_back(cyc);
        if (sb.size() == 0) begin
          check_val("unexpected_ack", 32'(o_ack_h), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_p = mon_e / 8;
          mon_d = mon_e % 8;
          check_val("ack_port", 32'(o_ack_h), 32'(1 << mon_p));
          check_val("ack_sel", 32'(o_selected_in), 32'(mon_p));
          check_val("grant_busy", 32'(o_out_busy[mon_d]), 32'd1);
          check_val("grant_mux", 32'(o_mux_out[mon_d*SEL_W +: SEL_W]), 32'(mon_p));
        end
        i_h = i_h & ~o_ack_h;
      end
    end
  end

  task automatic set_req(input int p, input logic [7:0] a);
    i_header_addr[p*ADDR_W +: ADDR_W] = a;
    i_h[p] = 1'b1;
  endtask

  task automatic expect_grant(input int p, input int d);
    sb.push_back(p * 8 + d);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check_val("grant_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
    #1;
  endtask

  task automatic rel(input logic [NPORT-1:0] m);
    @(negedge clock);
    i_release = m;
    @(negedge clock);
    i_release = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_ack", 32'(o_ack_h), 32'd0);
    check_val("rst_busy", 32'(o_out_busy), 32'd0);
    check_val("rst_mux", 32'(o_mux_out), 32'd0);
    check_val("rst_sel", 32'(o_selected_in), 32'd0);
    reset = 1'b1;

    // First request and latency
    set_req(4, 8'h21);
    expect_grant(4, 0);
    repeat (3) @(negedge clock);
    check_val("lat_early", 32'(o_ack_h), 32'd0);
    @(negedge clock);
    check_val("lat_ack", 32'(o_ack_h), 32'h10);
    wait_done(20);
    check_val("t1_busy", 32'(o_out_busy), 32'h01);
    check_val("t1_mux_east", 32'(o_mux_out[0 +: SEL_W]), 32'd4);
    rel(5'b00001);
    check_val("t1_release", 32'(o_out_busy), 32'd0);

    // XY decode sweep from the local port
    for (int i = 0; i < 5; i++) begin
      set_req(4, xy_addr[i]);
      expect_grant(4, xy_dst[i]);
      wait_done(30);
      check_val("xy_busy", 32'(o_out_busy), 32'(1 << xy_dst[i]));
      rel(5'b11111);
    end

    // Round robin across all inputs
    ack_log.delete();
    for (int p = 0; p < NPORT; p++) begin
      i_header_addr[p*ADDR_W +: ADDR_W] = rr_addr[p];
      expect_grant(p, p);
    end
    i_h = 5'b11111;
    wait_done(80);
    check_val("rr_count", 32'(ack_log.size()), 32'd5);
    if (ack_log.size() == 5) begin
      for (int i = 1; i < 5; i++) check_val("rr_gap", 32'(ack_log[i] - ack_log[i-1]), 32'd4);
    end
    check_val("rr_busy", 32'(o_out_busy), 32'h1f);
    rel(5'b11111);
    check_val("rr_release", 32'(o_out_busy), 32'd0);

    // Blocking on a busy output
    set_req(4, 8'h21);
    expect_grant(4, 0);
    wait_done(30);
    i_header_addr[1*ADDR_W +: ADDR_W] = 8'h21;
    i_header_addr[2*ADDR_W +: ADDR_W] = 8'h01;
    expect_grant(2, 1);
    i_h[1] = 1'b1;
    i_h[2] = 1'b1;
    wait_done(60);
    repeat (20) @(negedge clock);
    check_val("blk_busy", 32'(o_out_busy), 32'h03);
    check_val("blk_pending", 32'(i_h), 32'h02);
    expect_grant(1, 0);
    rel(5'b00001);
    wait_done(60);
    check_val("blk_mux_east", 32'(o_mux_out[0 +: SEL_W]), 32'd1);
    check_val("blk_busy_after", 32'(o_out_busy), 32'h03);
    rel(5'b11111);

    // Withdrawal during route
    set_req(3, 8'h10);
    repeat (2) @(negedge clock);
    i_h[3] = 1'b0;
    repeat (10) @(negedge clock);
    check_val("wd_busy", 32'(o_out_busy), 32'd0);
    check_val("wd_sel", 32'(o_selected_in), 32'd3);

    // Reset during grant
    set_req(2, 8'h01);
    expect_grant(2, 1);
    wait_done(30);
    check_val("rg_pre_busy", 32'(o_out_busy), 32'h02);
    set_req(0, 8'h21);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    i_h = '0;
    @(negedge clock);
    check_val("rg_ack", 32'(o_ack_h), 32'd0);
    check_val("rg_busy", 32'(o_out_busy), 32'd0);
    check_val("rg_mux", 32'(o_mux_out), 32'd0);
    check_val("rg_sel", 32'(o_selected_in), 32'd0);
    reset = 1'b1;

    // Spurious release
    rel(5'b11111);
    check_val("sp_busy", 32'(o_out_busy), 32'd0);
    check_val("sp_mux", 32'(o_mux_out), 32'd0);
    repeat (5) @(negedge clock);
    check_val("sp_ack", 32'(o_ack_h), 32'd0);

    // Normal operation after reset
    set_req(1, 8'h12);
    expect_grant(1, 2);
    wait_done(30);
    check_val("post_busy", 32'(o_out_busy), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_control.md
Name: switch_control

Overview:
- Central routing/allocation controller for one Phoenix router.
- Services header requests from the NPORT input buffers one at a time, in round-robin order.
- For each request it computes the XY output port and allocates that output if it is free, then drives the crossbar select table.
- Internally it uses a fixed-priority search over a rotated request vector, which yields round-robin fairness across input ports.

Parameters:
- NPORT, 5, number of router ports. Port index map: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- ADDR_W, 8, header target address width. X is the upper ADDR_W/2 bits, Y is the lower ADDR_W/2 bits.
- LOCAL_X, 1, X coordinate of this router.
- LOCAL_Y, 1, Y coordinate of this router.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- i_h  in  NPORT  per-input header-present request; held until acked.
- i_header_addr  in  NPORT*ADDR_W  per-input target address; slice i = bits [i*ADDR_W +: ADDR_W].
- i_release  in  NPORT  per-output end-of-packet; frees that output.
- o_ack_h  out  NPORT  one-cycle grant pulse to the served input.
- o_out_busy  out  NPORT  output port allocated.
- o_mux_out  out  NPORT*$clog2(NPORT)  per-output selected input index (crossbar select).
- o_selected_in  out  $clog2(NPORT)  input currently being serviced (debug/trace).

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to S_IDLE.
  - o_ack_h=0, o_out_busy=0, o_mux_out=0, o_selected_in=0.
  - Round-robin pointer = NPORT-1, so the first search starts at port 0.
  - Reset overrides everything mid-operation; any in-progress grant is dropped.
- FSM, one state per cycle:
  - S_IDLE: if |i_h, go to S_ARB; otherwise stay.
  - S_ARB: search i_h cyclically, starting at pointer+1 and wrapping at NPORT-1 to 0. Take the first set bit, register it as sel (o_selected_in), set pointer=sel, go to S_ROUTE. If i_h==0 by now, go to S_IDLE.
  - S_ROUTE:
    - If i_h[sel]==0 (request withdrawn), go to S_IDLE with no grant.
    - Otherwise compute dst by XY routing on addr=i_header_addr[sel] (all compares unsigned): tx>LOCAL_X gives EAST; tx<LOCAL_X gives WEST; else ty>LOCAL_Y gives NORTH; ty<LOCAL_Y gives SOUTH; else LOCAL.
    - If o_out_busy[dst]==0, go to S_GRANT. Otherwise go to S_IDLE with no grant (blocked).
    - Because pointer=sel, the next search begins after the blocked port.
  - S_GRANT:
    - o_ack_h[sel]=1 for exactly this cycle.
    - At this clock edge: o_out_busy[dst]<=1 and o_mux_out[dst]<=sel.
    - Next state is S_IDLE.
- Latency: if i_h is sampled nonzero in S_IDLE at edge k, o_ack_h is high during the cycle after edge k+3. Minimum 4 cycles between consecutive grants.
- o_ack_h is one-hot or zero; never more than one bit set.
- Release:
  - i_release[p]==1 at an edge with o_out_busy[p]==1 clears o_out_busy[p] at that edge. o_mux_out[p] holds its last value.
  - Release of a non-busy port is ignored.
  - Releases are processed in every state, including during S_ROUTE/S_GRANT for other ports.
- A release and a grant on the same output at the same edge cannot occur, because a grant requires busy==0 at S_ROUTE. If it is forced, the grant wins (busy=1).
- A U-turn (dst equals the input's own direction) is legal and is allocated normally.
- Multiple outputs may be busy simultaneously; each output has exactly one owner.

Test Plan:
- Reset then single request: reset low 2 cycles; i_h=5'b10000, addr[4]=8'h21 → o_ack_h=5'b10000 for 1 cycle at latency 4; o_out_busy=5'b00001; o_mux_out[EAST]=4.
- XY decode sweep, one at a time from port 4, releasing between requests:
  - 8'h01 → WEST (1)
  - 8'h12 → NORTH (2)
  - 8'h10 → SOUTH (3)
  - 8'h11 → LOCAL (4)
  - 8'h31 → EAST (0)
- Round-robin: i_h=5'b11111, each port targeting a distinct free output, acked port drops its i_h → acks in order 0,1,2,3,4, spaced 4 cycles apart.
- Blocking: EAST busy (owned by port 4); port 1 requests 8'h21, port 2 requests 8'h01 → port 1 gets no ack; port 2 is acked (WEST). Assert i_release[0] → port 1 acked on a later pass; o_mux_out[EAST]=1.
- Withdrawal and reset mid-op: drop i_h[sel] during S_ROUTE → no ack, return to S_IDLE. Assert reset during S_GRANT → o_ack_h=0 and o_out_busy=0 the next cycle.
- Spurious release: i_release=5'b11111 with nothing busy → all outputs unchanged at 0; no state change.
